// File: rtl/clk_mod_counter_pkg.sv
// clk_mod_counter_pkg: shared mode and direction encodings for clk_mod_counter
package clk_mod_counter_pkg;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
endpackage

// File: rtl/clk_prescaler.sv
// clk_prescaler: emits one tick per PRESC_DIV enabled cycles; phase frozen while enable is low
module clk_prescaler #(
    parameter int PRESC_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clr_sync,
    output logic tick
);
    localparam int PW = PRESC_DIV > 1 ? $clog2(PRESC_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESC_DIV - 1);
    logic [PW-1:0] cnt;
    assign tick = enable && cnt == LAST;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt <= '0;
        else if (clr_sync) cnt <= '0;
        else if (enable) cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/clk_mod_counter.sv
// clk_mod_counter: up/down modulo counter with wrap/saturate, load, prescaled enable, tc pulse and sticky ovf
module clk_mod_counter
    import clk_mod_counter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int PRESC_DIV = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] limit,
    input  logic             mode,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf
);
    logic             tick;
    logic             up;
    logic             term;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] bound;
    clk_prescaler #(.PRESC_DIV(PRESC_DIV)) u_presc (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .clr_sync (clr | load),
        .tick     (tick)
    );
    // Saturate tc marks only the entering step: next lands on the bound while current is not on it.
    always_comb begin
        up    = up_dn == DIR_UP;
        bound = up ? limit : '0;
        nxt   = up ? (out >= limit ? (mode == MODE_SAT ? limit : '0) : out + 1'b1)
                   : (out == '0 ? (mode == MODE_SAT ? '0 : limit) : out - 1'b1);
        term  = mode == MODE_SAT ? (nxt == bound && out != bound)
                                 : (up ? out >= limit : out == '0);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else if (clr) begin
            out <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else if (load) begin
            out <= load_val > limit ? limit : load_val;
            tc  <= 1'b0;
        end else if (tick) begin
            out <= nxt;
            tc  <= term;
            ovf <= ovf | term;
        end else begin
            tc  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_clk_mod_counter.sv
// tb_clk_mod_counter: directed checks of clk_mod_counter with PRESC_DIV=1 and PRESC_DIV=4 instances
module tb_clk_mod_counter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = '0;
    logic       up_dn = 1'b1;
    logic [7:0] limit = 8'd9;
    logic       mode = 1'b0;
    logic [7:0] out, out4;
    logic       tc, ovf, tc4, ovf4;
    logic [7:0] e_out;
    logic       e_tc, e_ovf;
    int checks = 0;
    int errors = 0;

    clk_mod_counter #(.WIDTH(8), .PRESC_DIV(1)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clr(clr), .load(load),
        .load_val(load_val), .up_dn(up_dn), .limit(limit), .mode(mode),
        .out(out), .tc(tc), .ovf(ovf)
    );
    clk_mod_counter #(.WIDTH(8), .PRESC_DIV(4)) dut4 (
        .clk(clk), .reset(reset), .enable(enable), .clr(clr), .load(load),
        .load_val(load_val), .up_dn(up_dn), .limit(limit), .mode(mode),
        .out(out4), .tc(tc4), .ovf(ovf4)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1; load = 1'b0; enable = 1'b0;
        cyc(1);
        clr = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] v);
        load_val = v; load = 1'b1;
        cyc(1);
        load = 1'b0;
    endtask

    task automatic test_reset();
        cyc(1);
        checks++;
        if ({out, tc, ovf} !== 10'h0) begin
            errors++; $display("FAIL reset_init got %0d/%0b/%0b exp 0/0/0", out, tc, ovf);
        end
        reset = 1'b0; limit = 8'd3; mode = 1'b0; up_dn = 1'b1; enable = 1'b1;
        cyc(4);
        checks++;
        if ({out, tc, ovf} !== {8'd0, 1'b1, 1'b1}) begin
            errors++; $display("FAIL reset_prewrap got %0d/%0b/%0b exp 0/1/1", out, tc, ovf);
        end
        enable = 1'b0; limit = 8'd9;
        do_load(8'd5);
        checks++;
        if ({out, tc, ovf} !== {8'd5, 1'b0, 1'b1}) begin
            errors++; $display("FAIL load_keeps_ovf got %0d/%0b/%0b exp 5/0/1", out, tc, ovf);
        end
        reset = 1'b1;
        #2;
        checks++;
        if ({out, tc, ovf, out4} !== 18'h0) begin
            errors++; $display("FAIL reset_async got %0d/%0b/%0b out4=%0d exp 0/0/0 0", out, tc, ovf, out4);
        end
        reset = 1'b0;
    endtask

    task automatic test_clr();
        limit = 8'd1; mode = 1'b0; up_dn = 1'b1; enable = 1'b1;
        cyc(3);
        checks++;
        if ({out, tc, ovf} !== {8'd1, 1'b0, 1'b1}) begin
            errors++; $display("FAIL clr_setup got %0d/%0b/%0b exp 1/0/1", out, tc, ovf);
        end
        clr = 1'b1; load = 1'b1; load_val = 8'd7;
        cyc(1);
        checks++;
        if ({out, tc, ovf} !== 10'h0) begin
            errors++; $display("FAIL clr_priority got %0d/%0b/%0b exp 0/0/0", out, tc, ovf);
        end
        clr = 1'b0; load = 1'b0; enable = 1'b0;
    endtask

    task automatic test_wrap_up();
        do_clr();
        limit = 8'd9; mode = 1'b0; up_dn = 1'b1; enable = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cyc(1);
            e_out = 8'(i % 10); e_tc = (i == 10); e_ovf = (i >= 10);
            checks++;
            if ({out, tc, ovf} !== {e_out, e_tc, e_ovf}) begin
                errors++; $display("FAIL wrap_up[%0d] got %0d/%0b/%0b exp %0d/%0b/%0b", i, out, tc, ovf, e_out, e_tc, e_ovf);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_sat_down();
        int sd[5] = '{2, 1, 0, 0, 0};
        do_clr();
        limit = 8'd20; mode = 1'b1; up_dn = 1'b0;
        do_load(8'd3);
        checks++;
        if ({out, tc, ovf} !== {8'd3, 1'b0, 1'b0}) begin
            errors++; $display("FAIL sat_down_load got %0d/%0b/%0b exp 3/0/0", out, tc, ovf);
        end
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            e_out = 8'(sd[i]); e_tc = (i == 2); e_ovf = (i >= 2);
            checks++;
            if ({out, tc, ovf} !== {e_out, e_tc, e_ovf}) begin
                errors++; $display("FAIL sat_down[%0d] got %0d/%0b/%0b exp %0d/%0b/%0b", i, out, tc, ovf, e_out, e_tc, e_ovf);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_sat_up();
        int su[4] = '{3, 4, 4, 4};
        do_clr();
        limit = 8'd4; mode = 1'b1; up_dn = 1'b1;
        do_load(8'd2);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            e_out = 8'(su[i]); e_tc = (i == 1); e_ovf = (i >= 1);
            checks++;
            if ({out, tc, ovf} !== {e_out, e_tc, e_ovf}) begin
                errors++; $display("FAIL sat_up[%0d] got %0d/%0b/%0b exp %0d/%0b/%0b", i, out, tc, ovf, e_out, e_tc, e_ovf);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_wrap_down();
        int wd[3] = '{0, 5, 4};
        do_clr();
        limit = 8'd5; mode = 1'b0; up_dn = 1'b0;
        do_load(8'd1);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            e_out = 8'(wd[i]); e_tc = (i == 1); e_ovf = (i >= 1);
            checks++;
            if ({out, tc, ovf} !== {e_out, e_tc, e_ovf}) begin
                errors++; $display("FAIL wrap_down[%0d] got %0d/%0b/%0b exp %0d/%0b/%0b", i, out, tc, ovf, e_out, e_tc, e_ovf);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_load_clamp();
        do_clr();
        limit = 8'd10; mode = 1'b0; up_dn = 1'b1;
        do_load(8'd200);
        checks++;
        if ({out, tc, ovf} !== {8'd10, 1'b0, 1'b0}) begin
            errors++; $display("FAIL load_clamp got %0d/%0b/%0b exp 10/0/0", out, tc, ovf);
        end
        enable = 1'b1;
        cyc(1);
        checks++;
        if ({out, tc, ovf} !== {8'd0, 1'b1, 1'b1}) begin
            errors++; $display("FAIL clamp_wrap got %0d/%0b/%0b exp 0/1/1", out, tc, ovf);
        end
        enable = 1'b0; limit = 8'd20;
        do_load(8'd15);
        limit = 8'd7; enable = 1'b1;
        cyc(1);
        checks++;
        if ({out, tc} !== {8'd0, 1'b1}) begin
            errors++; $display("FAIL limit_lowered_wrap got %0d/%0b exp 0/1", out, tc);
        end
        enable = 1'b0; limit = 8'd20;
        do_load(8'd15);
        limit = 8'd7; mode = 1'b1; enable = 1'b1;
        cyc(1);
        checks++;
        if (out !== 8'd7) begin
            errors++; $display("FAIL limit_lowered_sat got %0d exp 7", out);
        end
        enable = 1'b0; limit = 8'd20;
        do_load(8'd15);
        limit = 8'd7; up_dn = 1'b0; enable = 1'b1;
        cyc(1);
        checks++;
        if (out !== 8'd14) begin
            errors++; $display("FAIL limit_lowered_down got %0d exp 14", out);
        end
        enable = 1'b0; up_dn = 1'b1; mode = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_clr();
        limit = 8'd0; mode = 1'b0; up_dn = 1'b1; enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            checks++;
            if ({out, tc, ovf} !== {8'd0, 1'b1, 1'b1}) begin
                errors++; $display("FAIL limit0_wrap[%0d] got %0d/%0b/%0b exp 0/1/1", i, out, tc, ovf);
            end
        end
        mode = 1'b1;
        cyc(1);
        checks++;
        if ({out, tc, ovf} !== {8'd0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL limit0_sat got %0d/%0b/%0b exp 0/0/1", out, tc, ovf);
        end
        enable = 1'b0; mode = 1'b0;
    endtask

    task automatic test_max_width();
        do_clr();
        limit = 8'd255; mode = 1'b0; up_dn = 1'b1;
        do_load(8'd254);
        enable = 1'b1;
        cyc(1);
        checks++;
        if ({out, tc, ovf} !== {8'd255, 1'b0, 1'b0}) begin
            errors++; $display("FAIL max_255 got %0d/%0b/%0b exp 255/0/0", out, tc, ovf);
        end
        cyc(1);
        checks++;
        if ({out, tc, ovf} !== {8'd0, 1'b1, 1'b1}) begin
            errors++; $display("FAIL max_wrap got %0d/%0b/%0b exp 0/1/1", out, tc, ovf);
        end
        enable = 1'b0;
    endtask

    task automatic test_prescale();
        do_clr();
        limit = 8'd9; mode = 1'b0; up_dn = 1'b1; enable = 1'b1;
        cyc(4);
        checks++;
        if (out4 !== 8'd1) begin
            errors++; $display("FAIL presc_first got %0d exp 1", out4);
        end
        cyc(8);
        checks++;
        if ({out4, tc4} !== {8'd3, 1'b0}) begin
            errors++; $display("FAIL presc_12 got %0d/%0b exp 3/0", out4, tc4);
        end
        do_clr();
        for (int i = 0; i < 16; i++) begin
            enable = (i % 4) < 2;
            cyc(1);
        end
        checks++;
        if (out4 !== 8'd2) begin
            errors++; $display("FAIL presc_gapped got %0d exp 2", out4);
        end
        do_clr();
        enable = 1'b1; cyc(3);
        enable = 1'b0; cyc(5);
        checks++;
        if (out4 !== 8'd0) begin
            errors++; $display("FAIL presc_frozen got %0d exp 0", out4);
        end
        enable = 1'b1; cyc(1);
        checks++;
        if (out4 !== 8'd1) begin
            errors++; $display("FAIL presc_resume got %0d exp 1", out4);
        end
        do_clr();
        enable = 1'b1; cyc(3);
        enable = 1'b0;
        do_load(8'd0);
        enable = 1'b1; cyc(1);
        checks++;
        if (out4 !== 8'd0) begin
            errors++; $display("FAIL presc_load_clears got %0d exp 0", out4);
        end
        cyc(3);
        checks++;
        if (out4 !== 8'd1) begin
            errors++; $display("FAIL presc_after_load got %0d exp 1", out4);
        end
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clr();
        test_wrap_up();
        test_sat_down();
        test_sat_up();
        test_wrap_down();
        test_load_clamp();
        test_back_to_back();
        test_max_width();
        test_prescale();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
